// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: turns control-unit level memory requests into a registered req/ack bus transaction.
// Define MIO_TIMEOUT_EN to compile in the abort-on-missing-ack timeout (TIMEOUT cycles in REQ).
module mio_bus_ctrl #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_CPU_MIO,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_MIO_ready,
    output logic [31:0] o_rdata,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_next_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_we;
    logic        w_accept;
    logic        w_ack;
    logic        w_timeout;

    assign w_accept = (r_state == IDLE) && i_CPU_MIO && (i_MemRead || i_MemWrite);
    assign w_ack    = (r_state == REQ) && i_mem_ack;

`ifdef MIO_TIMEOUT_EN
    localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt;
    logic        r_bus_err;

    // An ack on the limit edge wins, so the abort only fires while ack is low.
    assign w_timeout = (r_state == REQ) && !i_mem_ack && (r_cnt == LP_LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= 16'd0;
            r_bus_err <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= 16'd0;
            r_bus_err <= 1'b0;
        end else if ((r_state == REQ) && !i_mem_ack) begin
            r_cnt <= r_cnt + 16'd1;
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign o_bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = REQ;
            REQ:     if (w_ack || w_timeout) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_mem_req   = 1'b0;
        o_MIO_ready = 1'b0;
        case (r_state)
            REQ:     o_mem_req   = 1'b1;
            DONE:    o_MIO_ready = 1'b1;
            default: ;
        endcase
    end

    // Write wins when both requests are asserted; writes leave rdata untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_rdata <= 32'd0;
        end else if (w_accept) begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_we    <= i_MemWrite;
        end else if (w_ack) begin
            if (!r_we) begin
                r_rdata <= i_mem_rdata;
            end
        end else if (w_timeout) begin
            if (!r_we) begin
                r_rdata <= ERR_DATA;
            end
        end
    end

    assign o_rdata     = r_rdata;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: scenario tasks drive mio_bus_ctrl; expected completions are queued at request time
// and popped when MIO_ready pulses. Timeout scenarios are built only with MIO_TIMEOUT_EN (TIMEOUT=4).
module tb_mio_bus_ctrl;

    localparam logic [31:0] ERR_VALUE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic        cpuMio;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mioReady;
    logic [31:0] rdata;
    logic        busErr;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memAck;
    logic [31:0] memRdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] lastRdata = 32'd0;

    mio_bus_ctrl #(
        .TIMEOUT  (4),
        .ERR_DATA (ERR_VALUE)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_MemRead   (memRead),
        .i_MemWrite  (memWrite),
        .i_CPU_MIO   (cpuMio),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_MIO_ready (mioReady),
        .o_rdata     (rdata),
        .o_bus_err   (busErr),
        .o_mem_req   (memReq),
        .o_mem_we    (memWe),
        .o_mem_addr  (memAddr),
        .o_mem_wdata (memWdata),
        .i_mem_ack   (memAck),
        .i_mem_rdata (memRdata)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rd, input logic wr, input logic mio,
                                 input logic [31:0] a, input logic [31:0] d);
        memRead  = rd;
        memWrite = wr;
        cpuMio   = mio;
        addr     = a;
        wdata    = d;
    endtask

    task automatic pushExpected(input logic [31:0] r, input logic e);
        exp_t x;
        x.rdata = r;
        x.err   = e;
        expQ.push_back(x);
        lastRdata = r;
    endtask

    task automatic popExpected(output exp_t x, output bit ok);
        ok = (expQ.size() != 0);
        if (ok) begin
            x = expQ.pop_front();
        end else begin
            x.rdata = 32'd0;
            x.err   = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        memAck   = 1'b0;
        memRdata = 32'd0;
        #50;
        nChecks++;
        if ({memReq, memWe, mioReady, busErr} !== 4'b0000) begin
            nFails++;
            $display("[TB] FAIL reset_ctrl: observed req/we/ready/err=%b, expected 0000",
                     {memReq, memWe, mioReady, busErr});
        end
        nChecks++;
        if (memAddr !== 32'd0 || memWdata !== 32'd0 || rdata !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL reset_data: observed addr=%h wdata=%h rdata=%h, expected all 0",
                     memAddr, memWdata, rdata);
        end
        #53;
        rst_n = 1'b1;
        lastRdata = 32'd0;
    endtask

    task automatic test_zero_wait_read;
        exp_t e;
        bit   ok;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'd0);
        memAck   = 1'b1;
        memRdata = 32'h2010_0000;
        pushExpected(32'h2010_0000, 1'b0);
        @(negedge clk);
        nChecks++;
        if (memReq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL zw_no_comb_req: observed mem_req=%b, expected 0", memReq);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        nChecks++;
        if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h4 || mioReady !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL zw_req: observed req=%b we=%b addr=%h ready=%b, expected 1 0 00000004 0",
                     memReq, memWe, memAddr, mioReady);
        end
        @(negedge clk);
        popExpected(e, ok);
        nChecks++;
        if (!ok || mioReady !== 1'b1 || memReq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL zw_ready: observed ready=%b req=%b, expected 1 0", mioReady, memReq);
        end
        nChecks++;
        if (rdata !== e.rdata || busErr !== e.err) begin
            nFails++;
            $display("[TB] FAIL zw_rdata: observed rdata=%h err=%b, expected %h %b",
                     rdata, busErr, e.rdata, e.err);
        end
        memAck = 1'b0;
        @(negedge clk);
        nChecks++;
        if (mioReady !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL zw_ready_pulse: observed ready=%b, expected 0", mioReady);
        end
    endtask

    task automatic test_wait_write;
        exp_t e;
        bit   ok;
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A);
        memAck   = 1'b0;
        memRdata = 32'h7777_7777;
        pushExpected(lastRdata, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_0BAD);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nChecks++;
            if (memReq !== 1'b1 || memWe !== 1'b1 || mioReady !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL ws_ctrl[%0d]: observed req=%b we=%b ready=%b, expected 1 1 0",
                         i, memReq, memWe, mioReady);
            end
            nChecks++;
            if (memAddr !== 32'h10 || memWdata !== 32'hA5A5_5A5A) begin
                nFails++;
                $display("[TB] FAIL ws_latch[%0d]: observed addr=%h wdata=%h, expected 00000010 a5a55a5a",
                         i, memAddr, memWdata);
            end
            if (i == 3) begin
                memAck = 1'b1;
                applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        @(negedge clk);
        popExpected(e, ok);
        nChecks++;
        if (!ok || mioReady !== 1'b1 || rdata !== e.rdata) begin
            nFails++;
            $display("[TB] FAIL ws_done: observed ready=%b rdata=%h, expected 1 %h", mioReady, rdata, e.rdata);
        end
        memAck = 1'b0;
        @(negedge clk);
        nChecks++;
        if (mioReady !== 1'b0 || memReq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ws_idle: observed ready=%b req=%b, expected 0 0", mioReady, memReq);
        end
    endtask

    task automatic test_ignored;
        exp_t e;
        bit   ok;
        bit   quiet = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h80, 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (memReq !== 1'b0 || mioReady !== 1'b0) quiet = 1'b0;
        end
        nChecks++;
        if (!quiet) begin
            nFails++;
            $display("[TB] FAIL ign_no_mio: observed a bus request, expected none with CPU_MIO=0");
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'h1122_3344);
        memAck   = 1'b1;
        memRdata = 32'hDEAD_BEEF;
        pushExpected(lastRdata, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        nChecks++;
        if (memReq !== 1'b1 || memWe !== 1'b1 || memAddr !== 32'h40 || memWdata !== 32'h1122_3344) begin
            nFails++;
            $display("[TB] FAIL ign_both: observed req=%b we=%b addr=%h wdata=%h, expected 1 1 00000040 11223344",
                     memReq, memWe, memAddr, memWdata);
        end
        @(negedge clk);
        popExpected(e, ok);
        nChecks++;
        if (!ok || mioReady !== 1'b1 || rdata !== e.rdata) begin
            nFails++;
            $display("[TB] FAIL ign_both_done: observed ready=%b rdata=%h, expected 1 %h", mioReady, rdata, e.rdata);
        end
        memAck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        bit   ok;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'd0);
        memAck   = 1'b1;
        memRdata = 32'h1111_0000;
        pushExpected(32'h1111_0000, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        nChecks++;
        if (memReq !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL b2b_req1: observed req=%b, expected 1", memReq);
        end
        @(negedge clk);
        popExpected(e, ok);
        nChecks++;
        if (!ok || mioReady !== 1'b1 || rdata !== e.rdata) begin
            nFails++;
            $display("[TB] FAIL b2b_done1: observed ready=%b rdata=%h, expected 1 %h", mioReady, rdata, e.rdata);
        end
        memRdata = 32'h2222_0000;
        pushExpected(32'h2222_0000, 1'b0);
        @(negedge clk);
        nChecks++;
        if (mioReady !== 1'b0 || memReq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL b2b_gap: observed ready=%b req=%b, expected 0 0", mioReady, memReq);
        end
        @(negedge clk);
        nChecks++;
        if (memReq !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL b2b_req2: observed req=%b, expected 1", memReq);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        popExpected(e, ok);
        nChecks++;
        if (!ok || mioReady !== 1'b1 || rdata !== e.rdata) begin
            nFails++;
            $display("[TB] FAIL b2b_done2: observed ready=%b rdata=%h, expected 1 %h", mioReady, rdata, e.rdata);
        end
        memAck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_midreset;
        exp_t e;
        bit   ok;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 32'h0000_5555);
        memAck = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        nChecks++;
        if (memReq !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL mr_req: observed req=%b, expected 1", memReq);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({memReq, mioReady, memWe, busErr} !== 4'b0000 || memAddr !== 32'd0 || memWdata !== 32'd0
            || rdata !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL mr_async: observed req/ready/we/err=%b addr=%h wdata=%h rdata=%h, expected all 0",
                     {memReq, mioReady, memWe, busErr}, memAddr, memWdata, rdata);
        end
        lastRdata = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 32'd0);
        memAck   = 1'b1;
        memRdata = 32'hCAFE_F00D;
        pushExpected(32'hCAFE_F00D, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        nChecks++;
        if (memReq !== 1'b1 || memAddr !== 32'h300) begin
            nFails++;
            $display("[TB] FAIL mr_after_req: observed req=%b addr=%h, expected 1 00000300", memReq, memAddr);
        end
        @(negedge clk);
        popExpected(e, ok);
        nChecks++;
        if (!ok || mioReady !== 1'b1 || rdata !== e.rdata) begin
            nFails++;
            $display("[TB] FAIL mr_after_done: observed ready=%b rdata=%h, expected 1 %h", mioReady, rdata, e.rdata);
        end
        memAck = 1'b0;
        @(negedge clk);
    endtask

`ifdef MIO_TIMEOUT_EN
    task automatic test_timeout;
        exp_t e;
        bit   ok;
        bit   got = 1'b0;
        int   reqCycles = 0;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h500, 32'd0);
        memAck   = 1'b0;
        memRdata = 32'h3333_3333;
        pushExpected(ERR_VALUE, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mioReady === 1'b1) got = 1'b1;
            else if (memReq === 1'b1) reqCycles++;
        end
        popExpected(e, ok);
        nChecks++;
        if (!got || reqCycles != 4) begin
            nFails++;
            $display("[TB] FAIL to_latency: observed ready=%b after %0d REQ cycles, expected 1 after 4",
                     got, reqCycles);
        end
        nChecks++;
        if (!ok || rdata !== e.rdata || busErr !== e.err) begin
            nFails++;
            $display("[TB] FAIL to_abort: observed rdata=%h err=%b, expected %h %b", rdata, busErr, e.rdata, e.err);
        end
        @(negedge clk);
        nChecks++;
        if (busErr !== 1'b1 || mioReady !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL to_sticky: observed err=%b ready=%b, expected 1 0", busErr, mioReady);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h504, 32'd0);
        memAck   = 1'b1;
        memRdata = 32'h1234_5678;
        pushExpected(32'h1234_5678, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        nChecks++;
        if (busErr !== 1'b0 || memReq !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL to_clear: observed err=%b req=%b, expected 0 1", busErr, memReq);
        end
        @(negedge clk);
        popExpected(e, ok);
        nChecks++;
        if (!ok || mioReady !== 1'b1 || rdata !== e.rdata) begin
            nFails++;
            $display("[TB] FAIL to_clear_done: observed ready=%b rdata=%h, expected 1 %h", mioReady, rdata, e.rdata);
        end
        memAck = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h508, 32'd0);
        memRdata = 32'h55AA_55AA;
        pushExpected(32'h55AA_55AA, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) memAck = 1'b1;
        end
        @(negedge clk);
        popExpected(e, ok);
        nChecks++;
        if (!ok || mioReady !== 1'b1 || busErr !== 1'b0 || rdata !== e.rdata) begin
            nFails++;
            $display("[TB] FAIL to_ack_on_limit: observed ready=%b err=%b rdata=%h, expected 1 0 %h",
                     mioReady, busErr, rdata, e.rdata);
        end
        memAck = 1'b0;
        @(negedge clk);
    endtask
`else
    task automatic test_no_timeout;
        exp_t e;
        bit   ok;
        bit   stalled = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h400, 32'd0);
        memAck   = 1'b0;
        memRdata = 32'h0BAD_F00D;
        pushExpected(32'h0BAD_F00D, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (memReq !== 1'b1 || mioReady !== 1'b0 || busErr !== 1'b0) stalled = 1'b0;
        end
        nChecks++;
        if (!stalled) begin
            nFails++;
            $display("[TB] FAIL nt_wait: observed early completion or error, expected REQ held for 20 cycles");
        end
        memAck = 1'b1;
        @(negedge clk);
        popExpected(e, ok);
        nChecks++;
        if (!ok || mioReady !== 1'b1 || busErr !== 1'b0 || rdata !== e.rdata) begin
            nFails++;
            $display("[TB] FAIL nt_done: observed ready=%b err=%b rdata=%h, expected 1 0 %h",
                     mioReady, busErr, rdata, e.rdata);
        end
        memAck = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_ignored();
        test_back_to_back();
        test_midreset();
`ifdef MIO_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL scoreboard_drain: observed %0d pending, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mio_bus_ctrl.md
# mio_bus_ctrl

Memory-interface sequencer between the multi-cycle control unit and the unified instruction/data memory bus. It turns the control unit's level requests (MemRead, MemWrite, CPU_MIO) into a registered request/acknowledge bus transaction. It returns MIO_ready plus registered read data so the control FSM can leave its fetch and memory-access states. An optional timeout aborts a transaction that is never acknowledged.

## Interface
- TIMEOUT, 16, cycles in REQ without mem_ack before abort (used only with timeout compiled in; legal 2..65535)
- ERR_DATA, 32'hFFFF_FFFF, value loaded into rdata on an aborted read
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- MemRead  in  1  read request from control unit
- MemWrite  in  1  write request from control unit
- CPU_MIO  in  1  request qualifier; requests are ignored when 0
- addr  in  32  byte address (from IorD mux)
- wdata  in  32  store data (register B)
- MIO_ready  out  1  transaction complete; one-cycle pulse
- rdata  out  32  registered read data feeding IR/MDR
- bus_err  out  1  last transaction aborted; sticky until next accepted request
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched store data
- mem_ack  in  1  bus acknowledge
- mem_rdata  in  32  bus read data, valid when mem_ack=1

## Operation
- States: IDLE, REQ, DONE (2-bit encoding, IDLE=0).
- IDLE: a request is CPU_MIO & (MemRead | MemWrite). On the accepting edge:
  - latch addr and wdata.
  - set mem_we=MemWrite; write wins if both are asserted.
  - clear bus_err and the timeout counter.
  - go to REQ.
- REQ: mem_req=1. mem_addr, mem_wdata and mem_we hold their latched values.
  - mem_ack=1 at an edge: on a read, load rdata←mem_rdata; on a write, rdata is unchanged. Go to DONE.
- DONE: MIO_ready=1 and mem_req=0 for exactly one cycle, then unconditionally go to IDLE. No request is accepted in DONE.
- rdata holds its value until the next completed read or abort.
- Request inputs are ignored outside IDLE. Changes to addr, wdata, MemRead or MemWrite during REQ have no effect.
- mem_ack outside REQ is ignored.

## Timing
- Reset values (async, immediate on rst=0):
  - state=IDLE
  - mem_req=0, mem_we=0, MIO_ready=0, bus_err=0
  - mem_addr=0, mem_wdata=0, rdata=0
  - counter=0
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.
- Request sampled at edge E0 → mem_req high from E0 to E1.
- With mem_ack high at E1 → MIO_ready high from E1 to E2, with rdata valid → IDLE at E2. Minimum latency is 2 cycles.
- Each extra cycle of mem_ack=0 in REQ adds one cycle.
- Back-to-back: a request still asserted in IDLE after DONE is accepted at the next edge. Minimum spacing is 3 cycles per transaction.
- Reset mid-transaction: mem_req and MIO_ready drop asynchronously. The pending access is discarded, and the bus must tolerate a dropped request.

## Configuration
- MIO_TIMEOUT_EN defined:
  - A 16-bit counter increments each cycle in REQ with mem_ack=0.
  - When the counter equals TIMEOUT-1 and mem_ack=0 at an edge: go to DONE, set bus_err=1, and on a read load rdata←ERR_DATA.
  - MIO_ready pulses normally.
  - mem_ack=1 on the same edge as the limit takes priority: normal completion, bus_err=0.
- MIO_TIMEOUT_EN undefined:
  - No counter. REQ waits indefinitely for mem_ack. bus_err is tied to 0.

## Test plan
- Zero-wait read: rst low 100 ns then high; MemRead=1, CPU_MIO=1, addr=0x0000_0004; mem_ack=1 with mem_rdata=0x2010_0000 → mem_req high 1 cycle, MIO_ready pulses 2 cycles after the request edge, rdata=0x2010_0000, bus_err=0.
- Wait-state write: MemWrite=1, addr=0x10, wdata=0xA5A5_5A5A; mem_ack delayed 3 cycles → mem_we=1 and mem_addr=0x10 stable for 4 REQ cycles, MIO_ready 1 cycle later, rdata unchanged.
- Ignored requests: MemRead=1 with CPU_MIO=0 → stays IDLE, mem_req=0. MemRead and MemWrite both 1 → write issued (mem_we=1).
- Input change in REQ: change addr to 0x20 while waiting → mem_addr stays at the original latched value.
- Mid-transaction reset: assert rst=0 while in REQ → mem_req=0 and MIO_ready=0 immediately, all outputs at reset values. After release, a new read completes normally.
- Timeout (MIO_TIMEOUT_EN, TIMEOUT=4): read with mem_ack held 0 → MIO_ready after 4 REQ cycles, bus_err=1, rdata=0xFFFF_FFFF. Next request clears bus_err. A variant with ack on the limit edge → bus_err=0 and real data returned.
